// File: rtl/viol_event_logger.sv
// viol_event_logger: watches timing-check notifier regs, counts violations per
//   source, and queues {source, timestamp} records for a consumer.
// Latency: a notifier toggle gives ev_valid 2 cycles later into an empty FIFO
//   (detect, enqueue).
// Backpressure: ev_valid/ev_ready handshake; a full FIFO drops the lowest
//   pending event each cycle and counts it in drop_cnt.
// Ports:
//   clock, reset           - single clock, synchronous active-high reset
//   notifier[NUM_CHK]      - any toggle on bit i is one violation on source i
//   clr_stats              - clears counters, sticky flags, drop count (not FIFO)
//   ev_valid/ev_ready      - FIFO head handshake; ev_src/ev_ts describe the head
//   viol_cnt, viol_sticky  - per-source saturating counts and seen flags
//   drop_cnt, fifo_level   - lost-event count and current FIFO occupancy
module viol_event_logger #(
  parameter int NUM_CHK = 4,
  parameter int TS_W    = 16,
  parameter int DEPTH   = 8,
  parameter int CNT_W   = 8,
  localparam int SRC_W  = (NUM_CHK > 1) ? $clog2(NUM_CHK) : 1,
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int LVL_W  = $clog2(DEPTH) + 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_CHK-1:0]       notifier,
  input  logic                     clr_stats,
  output logic                     ev_valid,
  input  logic                     ev_ready,
  output logic [SRC_W-1:0]         ev_src,
  output logic [TS_W-1:0]          ev_ts,
  output logic [NUM_CHK*CNT_W-1:0] viol_cnt,
  output logic [NUM_CHK-1:0]       viol_sticky,
  output logic [CNT_W-1:0]         drop_cnt,
  output logic [LVL_W-1:0]         fifo_level
);

  logic [NUM_CHK-1:0]    notif_q;
  logic [NUM_CHK-1:0]    ev;
  logic [NUM_CHK-1:0]    pending;
  logic [TS_W-1:0]       ts;
  logic [CNT_W-1:0]      cnt [NUM_CHK];

  logic [SRC_W+TS_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      head_idx;

  logic [NUM_CHK-1:0]    sel_oh;
  logic [SRC_W-1:0]      sel_idx;
  logic [NUM_CHK-1:0]    consume;
  logic                  full;
  logic                  pop;
  logic                  push;
  logic                  drop;

  // Edge detect: any change against last cycle's value is a violation.
  assign ev = notifier ^ notif_q;

  // Lowest set bit of pending wins the single enqueue/drop slot.
  assign sel_oh = pending & (~pending + NUM_CHK'(1));

  always_comb begin
    sel_idx = '0;
    for (int i = NUM_CHK - 1; i >= 0; i--) begin
      if (pending[i]) sel_idx = SRC_W'(i);
    end
  end

  assign full     = (fifo_level == LVL_W'(DEPTH));
  assign ev_valid = (fifo_level != '0);
  assign pop      = ev_valid & ev_ready;
  // A pop in the same cycle frees the slot the push needs, so full is no obstacle.
  assign push     = (|pending) & (~full | pop);
  assign drop     = (|pending) & full & ~pop;
  assign consume  = (push | drop) ? sel_oh : '0;

  // When empty, present the entry just popped so the outputs do not wander.
  assign head_idx        = ev_valid ? rd_ptr : rd_ptr - PTR_W'(1);
  assign {ev_src, ev_ts} = mem[head_idx];

  // Storage carries no reset; only pointers and level define validity.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= {sel_idx, ts};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      notif_q    <= notifier;
      pending    <= '0;
      ts         <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      notif_q <= notifier;
      ts      <= ts + TS_W'(1);
      // A fresh event on a source being consumed this cycle re-arms it;
      // an event on an already-pending source simply merges.
      pending <= (pending & ~consume) | ev;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LVL_W'(1);
        2'b01:   fifo_level <= fifo_level - LVL_W'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // Statistics: clr_stats restarts counting but never loses a same-cycle event.
  always_ff @(posedge clock) begin
    if (reset) begin
      viol_sticky <= '0;
      drop_cnt    <= '0;
      for (int i = 0; i < NUM_CHK; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CHK; i++) begin
        if (clr_stats) begin
          cnt[i]         <= ev[i] ? CNT_W'(1) : '0;
          viol_sticky[i] <= ev[i];
        end else if (ev[i]) begin
          viol_sticky[i] <= 1'b1;
          if (cnt[i] != '1) cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
      if (clr_stats) begin
        drop_cnt <= drop ? CNT_W'(1) : '0;
      end else if (drop && drop_cnt != '1) begin
        drop_cnt <= drop_cnt + CNT_W'(1);
      end
    end
  end

  for (genvar g = 0; g < NUM_CHK; g++) begin : g_cnt_pack
    assign viol_cnt[g*CNT_W +: CNT_W] = cnt[g];
  end

endmodule

// File: tb/tb_viol_event_logger.sv
// tb_viol_event_logger: directed checks of viol_event_logger with default
//   parameters (4 sources, 16-bit timestamp, 8-deep FIFO, 8-bit counters).
// Expected timestamps come from a bench-side cycle count since reset release.
module tb_viol_event_logger;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  notifier = 4'b0000;
  logic        clr_stats = 1'b0;
  logic        ev_valid;
  logic        ev_ready = 1'b0;
  logic [1:0]  ev_src;
  logic [15:0] ev_ts;
  logic [31:0] viol_cnt;
  logic [3:0]  viol_sticky;
  logic [7:0]  drop_cnt;
  logic [3:0]  fifo_level;

  int          checks = 0;
  int          failures = 0;
  logic [15:0] ts_exp = 16'd0;
  logic [15:0] exp_ts [8];
  logic [15:0] t0;

  viol_event_logger dut (
    .clock       (clock),
    .reset       (reset),
    .notifier    (notifier),
    .clr_stats   (clr_stats),
    .ev_valid    (ev_valid),
    .ev_ready    (ev_ready),
    .ev_src      (ev_src),
    .ev_ts       (ev_ts),
    .viol_cnt    (viol_cnt),
    .viol_sticky (viol_sticky),
    .drop_cnt    (drop_cnt),
    .fifo_level  (fifo_level)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock; ts_exp tracks the DUT timestamp counter value in the new cycle.
  task automatic tick();
    @(posedge clock);
    ts_exp = reset ? 16'd0 : ts_exp + 16'd1;
    #1;
  endtask

  function automatic logic [7:0] cnt_of(input int i);
    return viol_cnt[i*8 +: 8];
  endfunction

  initial begin
    // Reset state
    repeat (3) tick();
    chk("rst_valid", ev_valid, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_cnt", viol_cnt, 0);
    chk("rst_sticky", viol_sticky, 0);
    chk("rst_drop", drop_cnt, 0);
    reset = 1'b0;

    // Single toggle on source 2, changing on the edge closing the ts=5 cycle
    repeat (6) tick();
    notifier = 4'b0100;
    tick();
    chk("single_pre_valid", ev_valid, 0);
    tick();
    chk("single_valid", ev_valid, 1);
    chk("single_src", ev_src, 2);
    chk("single_ts", ev_ts, 7);
    chk("single_cnt2", cnt_of(2), 1);
    chk("single_sticky", viol_sticky, 4'b0100);
    chk("single_level", fifo_level, 1);
    ev_ready = 1'b1;
    tick();
    chk("pop_level", fifo_level, 0);
    tick();
    chk("empty_pop_level", fifo_level, 0);
    chk("empty_pop_valid", ev_valid, 0);

    // Simultaneous toggle of sources 0,1,3 together with clr_stats
    clr_stats = 1'b1;
    notifier  = 4'b1111;
    t0 = ts_exp;
    tick();
    clr_stats = 1'b0;
    chk("clr_ev_cnt0", cnt_of(0), 1);
    chk("clr_ev_cnt2", cnt_of(2), 0);
    chk("clr_ev_sticky", viol_sticky, 4'b1011);
    tick();
    chk("sim_valid0", ev_valid, 1);
    chk("sim_src0", ev_src, 0);
    chk("sim_ts0", ev_ts, t0 + 16'd1);
    tick();
    chk("sim_src1", ev_src, 1);
    chk("sim_ts1", ev_ts, t0 + 16'd2);
    tick();
    chk("sim_src3", ev_src, 3);
    chk("sim_ts3", ev_ts, t0 + 16'd3);
    tick();
    chk("sim_done_valid", ev_valid, 0);
    chk("sim_cnt1", cnt_of(1), 1);
    chk("sim_cnt3", cnt_of(3), 1);

    // Merge: source 1 toggles again while still pending behind source 0
    notifier = 4'b1100;
    tick();
    notifier = 4'b1110;
    t0 = ts_exp;
    tick();
    chk("merge_src0", ev_src, 0);
    chk("merge_ts0", ev_ts, t0);
    tick();
    chk("merge_src1", ev_src, 1);
    chk("merge_ts1", ev_ts, t0 + 16'd1);
    tick();
    chk("merge_valid", ev_valid, 0);
    chk("merge_cnt1", cnt_of(1), 3);

    // Overflow: 10 spaced toggles on source 1 with the consumer stalled
    ev_ready  = 1'b0;
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    for (int k = 0; k < 10; k++) begin
      notifier = notifier ^ 4'b0010;
      if (k < 8) exp_ts[k] = ts_exp + 16'd1;
      repeat (3) tick();
    end
    chk("ovf_level", fifo_level, 8);
    chk("ovf_drop", drop_cnt, 2);
    chk("ovf_cnt1", cnt_of(1), 10);
    chk("ovf_head_src", ev_src, 1);
    chk("ovf_head_ts", ev_ts, exp_ts[0]);

    // Full FIFO: push of a new event coincides with a pop
    notifier = notifier ^ 4'b0100;
    tick();
    t0 = ts_exp;
    ev_ready = 1'b1;
    tick();
    ev_ready = 1'b0;
    chk("fpp_level", fifo_level, 8);
    chk("fpp_drop", drop_cnt, 2);

    // Drain in order: seven remaining source-1 entries, then source 2
    for (int k = 0; k < 8; k++) begin
      chk("drain_valid", ev_valid, 1);
      chk("drain_src", ev_src, (k < 7) ? 1 : 2);
      chk("drain_ts", ev_ts, (k < 7) ? exp_ts[k+1] : t0);
      ev_ready = 1'b1;
      tick();
      ev_ready = 1'b0;
    end
    chk("drain_level", fifo_level, 0);

    // Saturation: 300 back-to-back toggles on source 0
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    for (int k = 0; k < 300; k++) begin
      notifier = notifier ^ 4'b0001;
      tick();
    end
    repeat (3) tick();
    chk("sat_cnt0", cnt_of(0), 255);
    chk("sat_drop", drop_cnt, 255);
    chk("sat_level", fifo_level, 8);
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    chk("clr_cnt", viol_cnt, 0);
    chk("clr_sticky", viol_sticky, 0);
    chk("clr_drop", drop_cnt, 0);
    chk("clr_level", fifo_level, 8);

    // Reset mid-stream with level 5 and an event pending
    ev_ready = 1'b1;
    repeat (3) tick();
    ev_ready = 1'b0;
    chk("rm_level5", fifo_level, 5);
    notifier = notifier ^ 4'b1000;
    tick();
    chk("rm_cnt3_pre", cnt_of(3), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rm_level", fifo_level, 0);
    chk("rm_valid", ev_valid, 0);
    repeat (4) tick();
    chk("rm_level_after", fifo_level, 0);
    chk("rm_valid_after", ev_valid, 0);
    chk("rm_cnt_after", viol_cnt, 0);
    chk("rm_sticky_after", viol_sticky, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
